// File: rtl/mem_writeback_if.sv
// mem_writeback_if: doubleword data-memory port between the memory/writeback
// stage (master) and the data memory (slave).
//   outMemReqValid  master->slave  request valid (held until inMemReqReady)
//   inMemReqReady   slave->master  request accepted on a valid&ready edge
//   outMemAddr      master->slave  doubleword-aligned address
//   outMemWrite     master->slave  1 = store, 0 = load
//   outMemWData     master->slave  lane-shifted store data
//   outMemWStrb     master->slave  byte strobes
//   inMemRespValid  slave->master  load data returned / store acknowledged
//   inMemRespData   slave->master  load doubleword
interface mem_writeback_if #(
    parameter int BUS_DATA_WIDTH = 64
);
    logic                          outMemReqValid;
    logic                          inMemReqReady;
    logic [BUS_DATA_WIDTH-1:0]     outMemAddr;
    logic                          outMemWrite;
    logic [BUS_DATA_WIDTH-1:0]     outMemWData;
    logic [BUS_DATA_WIDTH/8-1:0]   outMemWStrb;
    logic                          inMemRespValid;
    logic [BUS_DATA_WIDTH-1:0]     inMemRespData;

    modport master (
        output outMemReqValid, outMemAddr, outMemWrite, outMemWData, outMemWStrb,
        input  inMemReqReady, inMemRespValid, inMemRespData
    );

    modport slave (
        input  outMemReqValid, outMemAddr, outMemWrite, outMemWData, outMemWStrb,
        output inMemReqReady, inMemRespValid, inMemRespData
    );
endinterface

// File: rtl/mem_writeback.sv
// mem_writeback: combined memory-access and writeback stage of the RV64IM
// pipeline. Takes one executed instruction at a time, runs loads/stores on a
// doubleword memory port, aligns/extends load data and drives the register
// file write port. Stalls upstream while a memory access is outstanding.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   inValid .. inStoreType  executed instruction and its decode control bits
//   outStall                upstream must hold its inputs
//   mem                     data-memory port (mem_writeback_if.master)
//   outRegWrite/outDestRegister/outRegData  register-file write (1-cycle pulse)
//   outMisaligned           1-cycle pulse when an access is dropped
module mem_writeback #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      inValid,
    input  logic [BUS_DATA_WIDTH-1:0] inAluResult,
    input  logic [BUS_DATA_WIDTH-1:0] inStoreData,
    input  logic [4:0]                inDestRegister,
    input  logic                      inRegWrite,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inMemOrReg,
    input  logic [2:0]                inLoadType,
    input  logic [1:0]                inStoreType,
    output logic                      outStall,
    mem_writeback_if.master           mem,
    output logic                      outRegWrite,
    output logic [4:0]                outDestRegister,
    output logic [BUS_DATA_WIDTH-1:0] outRegData,
    output logic                      outMisaligned
);
    localparam int NB = BUS_DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Load/store selection is decided by inMemRead/inMemWrite alone; the
    // writeback source is implied by the kind of instruction.
    logic unused_mem_or_reg;
    assign unused_mem_or_reg = inMemOrReg;

    logic [1:0]                state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]                lane_q, lane_d;
    logic                      is_store_q, is_store_d;
    logic [2:0]                load_type_q, load_type_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]             wstrb_q, wstrb_d;
    logic [4:0]                rd_q, rd_d;
    logic                      reg_we_q, reg_we_d;
    logic                      wb_en_q, wb_en_d;
    logic [4:0]                wb_rd_q, wb_rd_d;
    logic [BUS_DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                      misaligned_q, misaligned_d;

    // Incoming access decode
    logic [2:0]                in_lane;
    logic [3:0]                acc_bytes;
    logic                      in_misaligned;
    logic [NB-1:0]             strb_new;
    logic                      mem_op;

    assign in_lane = inAluResult[2:0];
    assign mem_op  = inMemRead | inMemWrite;

    always_comb begin
        acc_bytes = 4'd8;
        if (inMemWrite) begin
            case (inStoreType)
                2'b00:   acc_bytes = 4'd8;
                2'b01:   acc_bytes = 4'd4;
                2'b10:   acc_bytes = 4'd2;
                default: acc_bytes = 4'd1;
            endcase
        end else begin
            case (inLoadType)
                3'b001, 3'b100: acc_bytes = 4'd1;
                3'b010, 3'b101: acc_bytes = 4'd2;
                3'b011, 3'b110: acc_bytes = 4'd4;
                default:        acc_bytes = 4'd8;
            endcase
        end
    end

    // For power-of-two sizes, (size-1) masks the lane bits that must be zero;
    // size 8 wraps to 3'b111 in three bits, which is exactly the ld/sd rule.
    assign in_misaligned = |(in_lane & (acc_bytes[2:0] - 3'd1));

    // A byte is enabled when it lies in [lane, lane+size).
    for (genvar gi = 0; gi < NB; gi++) begin : g_strb
        assign strb_new[gi] = (4'(gi) >= {1'b0, in_lane}) &&
                              (4'(gi) < ({1'b0, in_lane} + acc_bytes));
    end

    // Load extraction from the returned doubleword
    logic [BUS_DATA_WIDTH-1:0] resp_shift;
    logic [BUS_DATA_WIDTH-1:0] load_value;

    assign resp_shift = mem.inMemRespData >> {lane_q, 3'b000};

    always_comb begin
        case (load_type_q)
            3'b001:  load_value = {{(BUS_DATA_WIDTH-8){resp_shift[7]}},   resp_shift[7:0]};
            3'b010:  load_value = {{(BUS_DATA_WIDTH-16){resp_shift[15]}}, resp_shift[15:0]};
            3'b011:  load_value = {{(BUS_DATA_WIDTH-32){resp_shift[31]}}, resp_shift[31:0]};
            3'b100:  load_value = {{(BUS_DATA_WIDTH-8){1'b0}},  resp_shift[7:0]};
            3'b101:  load_value = {{(BUS_DATA_WIDTH-16){1'b0}}, resp_shift[15:0]};
            3'b110:  load_value = {{(BUS_DATA_WIDTH-32){1'b0}}, resp_shift[31:0]};
            default: load_value = resp_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        is_store_d   = is_store_q;
        load_type_d  = load_type_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rd_d         = rd_q;
        reg_we_d     = reg_we_q;
        wb_en_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        misaligned_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inValid) begin
                    if (!mem_op) begin
                        wb_en_d   = inRegWrite && (inDestRegister != 5'd0);
                        wb_rd_d   = inDestRegister;
                        wb_data_d = inAluResult;
                    end else if (in_misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d      = {inAluResult[BUS_DATA_WIDTH-1:3], 3'b000};
                        lane_d      = in_lane;
                        is_store_d  = inMemWrite;
                        load_type_d = inLoadType;
                        wdata_d     = inStoreData << {in_lane, 3'b000};
                        wstrb_d     = strb_new;
                        rd_d        = inDestRegister;
                        reg_we_d    = inRegWrite && (inDestRegister != 5'd0);
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.inMemReqReady) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.inMemRespValid) begin
                    state_d = ST_IDLE;
                    if (!is_store_q) begin
                        wb_en_d   = reg_we_q;
                        wb_rd_d   = rd_q;
                        wb_data_d = load_value;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            lane_q       <= '0;
            is_store_q   <= 1'b0;
            load_type_q  <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rd_q         <= '0;
            reg_we_q     <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            is_store_q   <= is_store_d;
            load_type_q  <= load_type_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rd_q         <= rd_d;
            reg_we_q     <= reg_we_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Valid and stall decode straight from state so a reset drops them at once.
    assign outStall           = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign mem.outMemReqValid = (state_q == ST_REQ);
    assign mem.outMemAddr     = addr_q;
    assign mem.outMemWrite    = is_store_q;
    assign mem.outMemWData    = wdata_q;
    assign mem.outMemWStrb    = wstrb_q;
    assign outRegWrite        = wb_en_q;
    assign outDestRegister    = wb_rd_q;
    assign outRegData         = wb_data_q;
    assign outMisaligned      = misaligned_q;
endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        inValid;
    logic [63:0] inAluResult;
    logic [63:0] inStoreData;
    logic [4:0]  inDestRegister;
    logic        inRegWrite, inMemRead, inMemWrite, inMemOrReg;
    logic [2:0]  inLoadType;
    logic [1:0]  inStoreType;
    logic        outStall;
    logic        outRegWrite;
    logic [4:0]  outDestRegister;
    logic [63:0] outRegData;
    logic        outMisaligned;

    int n_vec  = 0;
    int n_miss = 0;

    mem_writeback_if #(.BUS_DATA_WIDTH(64)) mif ();

    mem_writeback #(.BUS_DATA_WIDTH(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .inValid         (inValid),
        .inAluResult     (inAluResult),
        .inStoreData     (inStoreData),
        .inDestRegister  (inDestRegister),
        .inRegWrite      (inRegWrite),
        .inMemRead       (inMemRead),
        .inMemWrite      (inMemWrite),
        .inMemOrReg      (inMemOrReg),
        .inLoadType      (inLoadType),
        .inStoreType     (inStoreType),
        .outStall        (outStall),
        .mem             (mif),
        .outRegWrite     (outRegWrite),
        .outDestRegister (outDestRegister),
        .outRegData      (outRegData),
        .outMisaligned   (outMisaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic is_st, input logic [2:0] lt, input logic [1:0] st);
        if (is_st) return 8 >> st;
        case (lt)
            3'd0:       return 8;
            3'd1, 3'd4: return 1;
            3'd2, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] lt, input int lane, input logic [63:0] resp);
        int          sz;
        logic [63:0] mask;
        logic [63:0] v;
        sz   = acc_size(1'b0, lt, 2'b00);
        mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        v    = (resp >> (8 * lane)) & mask;
        if (lt >= 3'd1 && lt <= 3'd3 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic garbage_inputs();
        inValid        = 1'b1;
        inAluResult    = {$urandom, $urandom};
        inStoreData    = {$urandom, $urandom};
        inDestRegister = 5'd7;
        inRegWrite     = 1'b1;
        inMemRead      = 1'b0;
        inMemWrite     = 1'b0;
    endtask

    // Issue one instruction from IDLE and play the memory side; returns with DUT idle.
    task automatic run_op(input logic memr, input logic memw, input logic [2:0] lt,
                          input logic [1:0] st, input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [4:0] rd, input logic regw, input logic [63:0] resp,
                          input int rdy_dly, input int rsp_dly);
        int          sz, lane, m;
        logic        mis;
        logic [63:0] eaddr, ewd;
        logic [7:0]  estb;
        lane  = int'(addr[2:0]);
        sz    = acc_size(memw, lt, st);
        mis   = (memr || memw) && ((lane % sz) != 0);
        eaddr = addr & ~64'h7;
        ewd   = sdata << (8 * lane);
        m     = ((1 << sz) - 1) << lane;
        estb  = m[7:0];

        inValid = 1'b1; inAluResult = addr; inStoreData = sdata; inDestRegister = rd;
        inRegWrite = regw; inMemRead = memr; inMemWrite = memw; inMemOrReg = memr;
        inLoadType = lt; inStoreType = st;
        step();
        inValid = 1'b0;

        if (!(memr || memw)) begin
            chk("alu_we",    outRegWrite, regw && (rd != 0));
            chk("alu_rd",    outDestRegister, rd);
            chk("alu_data",  outRegData, addr);
            chk("alu_stall", outStall, 0);
            step();
            chk("alu_pulse", outRegWrite, 0);
        end else if (mis) begin
            chk("mis_pulse", outMisaligned, 1);
            chk("mis_req",   mif.outMemReqValid, 0);
            chk("mis_stall", outStall, 0);
            chk("mis_we",    outRegWrite, 0);
            step();
            chk("mis_end",   outMisaligned, 0);
            chk("mis_req2",  mif.outMemReqValid, 0);
        end else begin
            chk("req_valid", mif.outMemReqValid, 1);
            chk("req_stall", outStall, 1);
            chk("req_addr",  mif.outMemAddr, eaddr);
            chk("req_write", mif.outMemWrite, memw);
            if (memw) begin
                chk("req_wdata", mif.outMemWData, ewd);
                chk("req_wstrb", mif.outMemWStrb, estb);
            end
            // Hold ready low; stray responses and inValid must be ignored in REQ.
            for (int i = 0; i < rdy_dly; i++) begin
                garbage_inputs();
                mif.inMemReqReady  = 1'b0;
                mif.inMemRespValid = 1'b1;
                mif.inMemRespData  = {$urandom, $urandom};
                step();
                chk("hold_valid", mif.outMemReqValid, 1);
                chk("hold_addr",  mif.outMemAddr, eaddr);
                chk("hold_stall", outStall, 1);
                if (memw) begin
                    chk("hold_wdata", mif.outMemWData, ewd);
                    chk("hold_wstrb", mif.outMemWStrb, estb);
                end
            end
            mif.inMemRespValid = 1'b0;
            mif.inMemReqReady  = 1'b1;
            step();
            mif.inMemReqReady = 1'b0;
            chk("wait_valid", mif.outMemReqValid, 0);
            chk("wait_stall", outStall, 1);
            for (int i = 0; i < rsp_dly; i++) begin
                garbage_inputs();
                step();
                chk("wait2_stall", outStall, 1);
                chk("wait2_we",    outRegWrite, 0);
            end
            inValid = 1'b0;
            mif.inMemRespValid = 1'b1;
            mif.inMemRespData  = resp;
            step();
            mif.inMemRespValid = 1'b0;
            mif.inMemRespData  = {$urandom, $urandom};
            chk("resp_stall", outStall, 0);
            chk("resp_we",    outRegWrite, memr && !memw && regw && (rd != 0));
            if (!memw) begin
                chk("resp_rd",   outDestRegister, rd);
                chk("resp_data", outRegData, model_load(lt, lane, resp));
            end
            step();
            chk("resp_pulse", outRegWrite, 0);
            chk("idle_stall", outStall, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        inValid = 1'b0; inAluResult = '0; inStoreData = '0; inDestRegister = '0;
        inRegWrite = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0; inMemOrReg = 1'b0;
        inLoadType = '0; inStoreType = '0;
        mif.inMemReqReady = 1'b0; mif.inMemRespValid = 1'b0; mif.inMemRespData = '0;
        step();
        step();
        chk("rst_stall", outStall, 0);
        chk("rst_req",   mif.outMemReqValid, 0);
        chk("rst_addr",  mif.outMemAddr, 0);
        chk("rst_wdata", mif.outMemWData, 0);
        chk("rst_wstrb", mif.outMemWStrb, 0);
        chk("rst_data",  outRegData, 0);
        chk("rst_mis",   outMisaligned, 0);
        reset_n = 1'b1;
        step();

        // Directed cases
        run_op(0, 0, 3'd0, 2'd0, 64'h1234, 64'h0, 5'd5, 1, 64'h0, 0, 0);            // add rd=5
        run_op(0, 0, 3'd0, 2'd0, 64'h5678, 64'h0, 5'd0, 1, 64'h0, 0, 0);            // x0 write
        run_op(1, 0, 3'd1, 2'd0, 64'h1003, 64'h0, 5'd3, 1, 64'h0000_0000_80FF_0000, 0, 0); // lb
        run_op(1, 0, 3'd4, 2'd0, 64'h1003, 64'h0, 5'd4, 1, 64'h0000_0000_80FF_0000, 0, 0); // lbu
        run_op(0, 1, 3'd0, 2'd2, 64'h2006, 64'hBEEF, 5'd9, 1, 64'h0, 0, 1);        // sh
        run_op(1, 0, 3'd3, 2'd0, 64'h4004, 64'h0, 5'd10, 1, 64'h8765_4321_DEAD_BEEF, 3, 2); // lw stalled
        run_op(0, 1, 3'd0, 2'd1, 64'h3002, 64'h1111, 5'd1, 0, 64'h0, 0, 0);        // sw misaligned
        run_op(1, 0, 3'd0, 2'd0, 64'h5008, 64'h0, 5'd11, 1, 64'hFEDC_BA98_7654_3210, 0, 0); // ld

        // Back-to-back non-memory ops
        inValid = 1'b1; inMemRead = 1'b0; inMemWrite = 1'b0; inRegWrite = 1'b1;
        inDestRegister = 5'd12; inAluResult = 64'hAAAA;
        step();
        chk("b2b_a_we", outRegWrite, 1);
        chk("b2b_a",    outRegData, 64'hAAAA);
        inDestRegister = 5'd13; inAluResult = 64'hBBBB;
        step();
        chk("b2b_b_we", outRegWrite, 1);
        chk("b2b_b_rd", outDestRegister, 13);
        chk("b2b_b",    outRegData, 64'hBBBB);
        inValid = 1'b0;
        step();
        chk("b2b_end",  outRegWrite, 0);

        // Reset during WAIT: access aborted, late response ignored
        inValid = 1'b1; inAluResult = 64'h6000; inMemRead = 1'b1; inMemWrite = 1'b0;
        inLoadType = 3'd3; inDestRegister = 5'd14; inRegWrite = 1'b1;
        step();
        inValid = 1'b0;
        chk("abort_req", mif.outMemReqValid, 1);
        mif.inMemReqReady = 1'b1;
        step();
        mif.inMemReqReady = 1'b0;
        chk("abort_wait", outStall, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_stall", outStall, 0);
        chk("abort_valid", mif.outMemReqValid, 0);
        chk("abort_addr",  mif.outMemAddr, 0);
        step();
        reset_n = 1'b1;
        mif.inMemRespValid = 1'b1; mif.inMemRespData = 64'h1;
        step();
        mif.inMemRespValid = 1'b0;
        chk("late_we",    outRegWrite, 0);
        chk("late_stall", outStall, 0);
        step();
        chk("late_we2",   outRegWrite, 0);

        // Reset during REQ
        inValid = 1'b1; inAluResult = 64'h7000; inMemRead = 1'b0; inMemWrite = 1'b1;
        inStoreType = 2'd0; inStoreData = 64'h55;
        step();
        inValid = 1'b0;
        chk("rreq_valid", mif.outMemReqValid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rreq_drop",  mif.outMemReqValid, 0);
        chk("rreq_wstrb", mif.outMemWStrb, 0);
        step();
        reset_n = 1'b1;
        step();

        // Randomized mix
        for (int t = 0; t < 60; t++) begin
            logic [63:0] a;
            int kind;
            kind = int'($urandom_range(0, 2));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'($urandom_range(0, 1) * 4); // bias toward aligned
            run_op(kind == 1, kind == 2, 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                   a, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
